// File: rtl/signal_fifo.sv
// Synchronous FIFO for signal words, each tagged with a batch-last flag.
// start_o tracks whether any batch-last word is buffered.
module signal_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  wr_ack_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_LINES:0]   count_o,
  output logic                  start_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned             DEPTH      = 2 ** ADDR_LINES;
  localparam logic [ADDR_LINES:0]     FULL_COUNT = (ADDR_LINES + 1)'(DEPTH);

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_LINES-1:0] r_wr_ptr;
  logic [ADDR_LINES-1:0] r_rd_ptr;
  logic [ADDR_LINES:0]   r_count;
  logic [ADDR_LINES:0]   r_last_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH:0]   w_head;
  logic                  w_last_in;
  logic                  w_last_out;
  logic [ADDR_LINES:0]   w_count_nxt;
  logic [ADDR_LINES:0]   w_last_cnt_nxt;

  // Flags derive only from registered occupancy, never from the request inputs.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_wr_acc   = wr_en_i & ~w_full;
  assign w_rd_acc   = rd_en_i & ~w_empty;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_last_in  = w_wr_acc & last_i;
  assign w_last_out = w_rd_acc & w_head[DATA_WIDTH];

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_last_cnt_nxt = r_last_cnt;
    unique case ({w_last_in, w_last_out})
      2'b10:   w_last_cnt_nxt = r_last_cnt + 1'b1;
      2'b01:   w_last_cnt_nxt = r_last_cnt - 1'b1;
      default: w_last_cnt_nxt = r_last_cnt;
    endcase
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= {last_i, data_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_cnt  <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_last_cnt <= w_last_cnt_nxt;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= w_head[DATA_WIDTH-1:0];
        r_last   <= w_head[DATA_WIDTH];
      end
      if (wr_en_i && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en_i && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign wr_ack_o    = w_wr_acc;
  assign data_o      = r_data;
  assign last_o      = r_last;
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign count_o     = r_count;
  assign start_o     = (r_last_cnt != '0);
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_signal_fifo.sv
// Directed scenario bench for signal_fifo: fill, drain, wrap, simultaneous
// read/write, batch-last tracking and asynchronous reset mid-fill.
module tb_signal_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [31:0] data_i;
  logic        last_i;
  logic        wr_ack_o;
  logic        rd_en_i;
  logic [31:0] data_o;
  logic        last_o;
  logic        empty_o;
  logic        full_o;
  logic [5:0]  count_o;
  logic        start_o;
  logic        overflow_o;
  logic        underflow_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  signal_fifo #(
    .DATA_WIDTH (32),
    .ADDR_LINES (5)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_en_i     (wr_en_i),
    .data_i      (data_i),
    .last_i      (last_i),
    .wr_ack_o    (wr_ack_o),
    .rd_en_i     (rd_en_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .count_o     (count_o),
    .start_o     (start_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    #3;
    n_total++;
    if ({empty_o, full_o, count_o, start_o, overflow_o, underflow_o, last_o} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_flags: got e=%b f=%b cnt=%0d st=%b ov=%b un=%b lo=%b", empty_o, full_o, count_o, start_o, overflow_o, underflow_o, last_o);
    else n_pass++;
    n_total++;
    if (data_o !== 32'h0) $display("FAIL reset_data: got %h expected 0", data_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      wr_en_i = 1'b1;
      data_i  = 32'h100 + i;
      step();
      if (i == 0) begin
        n_total++;
        if (empty_o !== 1'b0 || count_o !== 6'd1) $display("FAIL fill_first: got empty=%b count=%0d expected 0/1", empty_o, count_o);
        else n_pass++;
      end
    end
    n_total++;
    if (full_o !== 1'b1 || count_o !== 6'd32) $display("FAIL fill_full: got full=%b count=%0d expected 1/32", full_o, count_o);
    else n_pass++;
    data_i = 32'hDEAD;
    #1;
    n_total++;
    if (wr_ack_o !== 1'b0) $display("FAIL fill_ack_when_full: got %b expected 0", wr_ack_o);
    else n_pass++;
    step();
    idle();
    n_total++;
    if (overflow_o !== 1'b1 || count_o !== 6'd32) $display("FAIL fill_overflow: got ov=%b count=%0d expected 1/32", overflow_o, count_o);
    else n_pass++;
  endtask

  task automatic test_drain();
    int unsigned bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_en_i = 1'b1;
      step();
      if (data_o !== 32'h100 + i) begin
        bad++;
        $display("FAIL drain_data[%0d]: got %h expected %h", i, data_o, 32'h100 + i);
      end
    end
    n_total++;
    if (bad == 0) n_pass++;
    n_total++;
    if (empty_o !== 1'b1 || count_o !== 6'd0) $display("FAIL drain_empty: got empty=%b count=%0d expected 1/0", empty_o, count_o);
    else n_pass++;
    n_total++;
    if (underflow_o !== 1'b0) $display("FAIL drain_no_early_underflow: got %b expected 0", underflow_o);
    else n_pass++;
    step();
    idle();
    n_total++;
    if (underflow_o !== 1'b1 || data_o !== 32'h11F) $display("FAIL drain_underflow: got un=%b data=%h expected 1/0000011f", underflow_o, data_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int unsigned bad_data = 0;
    int unsigned bad_cnt  = 0;
    for (int k = 0; k <= 40; k++) begin
      wr_en_i = (k < 40);
      rd_en_i = (k > 0);
      data_i  = 32'h400 + k;
      step();
      if (count_o > 6'd1) begin
        bad_cnt++;
        $display("FAIL wrap_count[%0d]: got %0d expected <=1", k, count_o);
      end
      if (k > 0 && data_o !== 32'h400 + k - 1) begin
        bad_data++;
        $display("FAIL wrap_data[%0d]: got %h expected %h", k, data_o, 32'h400 + k - 1);
      end
    end
    idle();
    n_total++;
    if (bad_data == 0) n_pass++;
    n_total++;
    if (bad_cnt == 0) n_pass++;
    n_total++;
    if (empty_o !== 1'b1) $display("FAIL wrap_empty: got %b expected 1", empty_o);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int unsigned bad = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en_i = 1'b1;
      data_i  = 32'h200 + i;
      step();
    end
    n_total++;
    if (count_o !== 6'd5) $display("FAIL simul_pre_count: got %0d expected 5", count_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      wr_en_i = 1'b1;
      rd_en_i = 1'b1;
      data_i  = 32'h205 + i;
      step();
      if (count_o !== 6'd5 || data_o !== 32'h200 + i) begin
        bad++;
        $display("FAIL simul_rw[%0d]: got count=%0d data=%h expected 5/%h", i, count_o, data_o, 32'h200 + i);
      end
    end
    n_total++;
    if (bad == 0) n_pass++;
    bad = 0;
    idle();
    for (int i = 0; i < 5; i++) begin
      rd_en_i = 1'b1;
      step();
      if (data_o !== 32'h203 + i) begin
        bad++;
        $display("FAIL simul_drain[%0d]: got %h expected %h", i, data_o, 32'h203 + i);
      end
    end
    idle();
    n_total++;
    if (bad == 0 && empty_o === 1'b1) n_pass++;
    else $display("FAIL simul_drain_end: got empty=%b bad=%0d expected 1/0", empty_o, bad);
  endtask

  task automatic test_last_flag();
    wr_en_i = 1'b1; data_i = 32'hA; last_i = 1'b0;
    step();
    n_total++;
    if (start_o !== 1'b0) $display("FAIL last_after_A: got start=%b expected 0", start_o);
    else n_pass++;
    data_i = 32'hB; last_i = 1'b1;
    step();
    n_total++;
    if (start_o !== 1'b1) $display("FAIL last_after_B: got start=%b expected 1", start_o);
    else n_pass++;
    data_i = 32'hC; last_i = 1'b1;
    step();
    idle();
    rd_en_i = 1'b1;
    step();
    n_total++;
    if (data_o !== 32'hA || last_o !== 1'b0 || start_o !== 1'b1) $display("FAIL last_read_A: got data=%h last=%b start=%b expected a/0/1", data_o, last_o, start_o);
    else n_pass++;
    step();
    n_total++;
    if (data_o !== 32'hB || last_o !== 1'b1 || start_o !== 1'b1) $display("FAIL last_read_B: got data=%h last=%b start=%b expected b/1/1", data_o, last_o, start_o);
    else n_pass++;
    step();
    idle();
    n_total++;
    if (data_o !== 32'hC || last_o !== 1'b1 || start_o !== 1'b0) $display("FAIL last_read_C: got data=%h last=%b start=%b expected c/1/0", data_o, last_o, start_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 7; i++) begin
      wr_en_i = 1'b1;
      data_i  = 32'h300 + i;
      last_i  = (i == 2);
      step();
    end
    idle();
    n_total++;
    if (count_o !== 6'd7 || start_o !== 1'b1) $display("FAIL mid_pre_count: got count=%0d start=%b expected 7/1", count_o, start_o);
    else n_pass++;
    #2;
    rst_i = 1'b1;
    #1;
    n_total++;
    if ({empty_o, full_o, count_o, start_o, overflow_o, underflow_o, last_o, data_o} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0})
      $display("FAIL mid_async_reset: got e=%b f=%b cnt=%0d st=%b ov=%b un=%b lo=%b d=%h", empty_o, full_o, count_o, start_o, overflow_o, underflow_o, last_o, data_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    wr_en_i = 1'b1;
    data_i  = 32'h3AA;
    step();
    idle();
    rd_en_i = 1'b1;
    step();
    idle();
    n_total++;
    if (data_o !== 32'h3AA || count_o !== 6'd0 || empty_o !== 1'b1) $display("FAIL mid_post_reset_rw: got data=%h count=%0d empty=%b expected 3aa/0/1", data_o, count_o, empty_o);
    else n_pass++;
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_last_flag();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
